matrix_mult_seq: RTL and testbench
==================================

Name: matrix_mult_seq

Overview:
Streaming, resource-shared successor to the combinational N×N matrix multiplier.
- Operands A and B load row-by-row over a valid/ready input stream.
- Product C = A·B is computed on LANES time-multiplexed MAC units, with optional accumulate (C += A·B) and signed modes.
- Result rows drain over a valid/ready output stream.
- Sits between the operand DMA/stream fabric and the result consumer in the compute datapath.

Parameters:
- N, 4, matrix dimension (≥2).
- WIDTH, 16, operand element width.
- LANES, 1, parallel MAC lanes; must divide N.
- SIGNED, 0, 1 = two's-complement operands/results, 0 = unsigned.
- ACC_W, 2*WIDTH+$clog2(N)+1, result element width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input row beat valid
- in_ready  out  1  block accepts input beat
- in_row  in  N*WIDTH  one matrix row; element j at bits [j*WIDTH +: WIDTH]
- acc_en  in  1  sampled with first A beat; 1 = accumulate into existing C
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts result row
- out_row  out  N*ACC_W  one C row; element j at bits [j*ACC_W +: ACC_W]
- out_idx  out  $clog2(N)  row index of out_row
- busy  out  1  high in COMPUTE or DRAIN
- done  out  1  one-cycle pulse on final drain beat accepted

Behaviour:
- Reset (rst_n low at edge): state=IDLE; all counters, C storage and acc flag cleared; in_ready=0, out_valid=0, out_row=0, out_idx=0, busy=0, done=0. Reset mid-operation abandons the job; no partial output.
- IDLE: goes to LOAD next cycle unconditionally.
- LOAD:
  - in_ready=1; beat accepted on in_valid&&in_ready.
  - Beats 0..N-1 are A rows 0..N-1; beats N..2N-1 are B rows 0..N-1.
  - acc_en is latched on beat 0 only.
  - The edge accepting beat 2N-1 enters COMPUTE.
  - in_valid gaps stall with no side effects.
- COMPUTE:
  - in_ready=0. Loop order: i outer, j-group (N/LANES) middle, k inner.
  - Each cycle, lane l adds A[i][k]*B[k][j0+l] into C[i][j0+l].
  - At k=0, the accumulator starts from 0 if the latched acc flag is 0, otherwise from stored C.
  - Takes exactly N*N*N/LANES cycles, then enters DRAIN.
  - out_valid first rises N³/LANES cycles after the last-B acceptance edge.
- DRAIN:
  - out_valid=1 holding row out_idx; out_row/out_idx stable while out_valid && !out_ready.
  - Advance on out_valid&&out_ready.
  - Acceptance of row N-1: pulse done for one cycle, clear out_valid, return to LOAD.
  - C storage retained for the next accumulate job.
- Arithmetic:
  - Products are 2*WIDTH, sign- or zero-extended per SIGNED to ACC_W.
  - Accumulation wraps modulo 2^ACC_W (default build).
  - ACC_W guarantees no overflow for a single non-accumulate job.
- busy=1 in COMPUTE and DRAIN only. in_ready and out_valid are never simultaneously high.

Optional Feature:
MATRIX_MULT_SEQ_SAT_EN
- Defined: each accumulate saturates to the ACC_W max/min (signed or unsigned per SIGNED) instead of wrapping. Adds output port ovf (1 bit), sticky; set on any saturation event; cleared by reset or by acceptance of the next beat-0 A row.
- Undefined: wrapping arithmetic; ovf port absent.

Decomposition:
- Package matrix_mult_pkg: state enum (IDLE, LOAD, COMPUTE, DRAIN) and ACC_W helper function.
- Sub-module mac_lane: one registered multiply-accumulate with SIGNED handling and the optional saturation logic. Instantiated LANES times via generate.

Test Plan:
1. N=4, LANES=1, A[i][j]=i+j, B=identity, acc_en=0 -> C rows {0 1 2 3},{1 2 3 4},{2 3 4 5},{3 4 5 6}; out_valid rises 64 cycles after last B accept; done pulses once.
2. Same job with LANES=4 -> identical C; out_valid rises 16 cycles after last B accept.
3. Job 1, then repeat the same job with acc_en=1 -> C = 2A, e.g. row 3 = {6 8 10 12}.
4. SIGNED=1, A all -1 (0xFFFF), B all 2 -> every C element = -8 (ACC_W-bit two's complement); SIGNED=0 with same bits -> 0xFFFF*2*4 = 524280.
5. Stall checks:
   - out_ready low for 5 cycles on row 1 -> out_row/out_idx held stable, no row skipped.
   - in_valid toggling during LOAD -> exactly 8 beats consumed, result as test 1.
6. Reset checks:
   - rst_n low for 1 cycle mid-COMPUTE -> next cycle all outputs at reset values.
   - Fresh job afterwards with acc_en=1 yields plain A·B (C was cleared).
   - With MATRIX_MULT_SEQ_SAT_EN: unsigned max operands accumulated repeatedly -> clamp at 2^ACC_W-1 and ovf=1.

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// Shared types for the streaming matrix multiplier: FSM state encoding and
// the accumulator-width rule.
package matrix_mult_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  // Wide enough that one non-accumulate job of N products never overflows.
  function automatic int acc_w(input int n, input int width);
    return 2 * width + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One registered multiply-accumulate lane; saturating adder when
// MATRIX_MULT_SEQ_SAT_EN is defined, wrapping adder otherwise.
module mac_lane import matrix_mult_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int ACC_W  = 35,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             first,
  input  logic             acc_flag,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [ACC_W-1:0] c_in,
  output logic [ACC_W-1:0] sum
`ifdef MATRIX_MULT_SEQ_SAT_EN
  , output logic           sat
`endif
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] a_x;
  logic [ACC_W-1:0] b_x;
  logic [ACC_W-1:0] prod;

  // Extending before the multiply keeps the low ACC_W product bits exact in both modes.
  assign a_x  = SIGNED ? {{(ACC_W-WIDTH){a[WIDTH-1]}}, a} : {{(ACC_W-WIDTH){1'b0}}, a};
  assign b_x  = SIGNED ? {{(ACC_W-WIDTH){b[WIDTH-1]}}, b} : {{(ACC_W-WIDTH){1'b0}}, b};
  assign prod = a_x * b_x;
  assign base = first ? (acc_flag ? c_in : '0) : acc_q;

`ifdef MATRIX_MULT_SEQ_SAT_EN
  logic [ACC_W:0] raw;
  assign raw = {1'b0, base} + {1'b0, prod};

  always_comb begin
    sat = 1'b0;
    sum = raw[ACC_W-1:0];
    if (SIGNED) begin
      if ((base[ACC_W-1] == prod[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1])) begin
        sat = 1'b1;
        sum = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (raw[ACC_W]) begin
      sat = 1'b1;
      sum = '1;
    end
  end
`else
  assign sum = base + prod;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)  acc_q <= '0;
    else if (en) acc_q <= sum;
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Streaming N x N matrix multiplier on LANES shared MAC units.
// Optional MATRIX_MULT_SEQ_SAT_EN: saturating accumulate plus sticky ovf output.
module matrix_mult_seq import matrix_mult_pkg::*; #(
  parameter int  N      = 4,
  parameter int  WIDTH  = 16,
  parameter int  LANES  = 1,
  parameter bit  SIGNED = 1'b0,
  localparam int ACC_W  = acc_w(N, WIDTH),
  localparam int IW     = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_row,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*ACC_W-1:0] out_row,
  output logic [IW-1:0]      out_idx,
  output logic               busy,
  output logic               done
`ifdef MATRIX_MULT_SEQ_SAT_EN
  , output logic             ovf
`endif
);

  localparam int            JG        = N / LANES;
  localparam int            BW        = IW + 1;
  localparam logic [IW-1:0] LAST      = IW'(N - 1);
  localparam logic [IW-1:0] JG_LAST   = IW'(JG - 1);
  localparam logic [BW-1:0] NB        = BW'(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(2 * N - 1);

  state_t            state, state_nxt;
  logic [BW-1:0]     beat;
  logic [IW-1:0]     ld_row;
  logic [IW-1:0]     ri, grp, rk;
  logic              acc_flag;
  logic              take, give, last_mac;
  logic [N*WIDTH-1:0] a_mem [N];
  logic [N*WIDTH-1:0] b_mem [N];
  logic [N*ACC_W-1:0] c_mem [N];
  logic [ACC_W-1:0]  lane_sum [LANES];
  logic [IW-1:0]     lane_col [LANES];
`ifdef MATRIX_MULT_SEQ_SAT_EN
  logic [LANES-1:0]  lane_sat;
`endif

  assign take     = in_valid && in_ready;
  assign give     = out_valid && out_ready;
  assign last_mac = (rk == LAST) && (grp == JG_LAST) && (ri == LAST);
  assign ld_row   = (beat < NB) ? beat[IW-1:0] : IW'(beat - NB);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_row   = '0;
    case (state)
      IDLE: state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (take && beat == LAST_BEAT) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_mac) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_row   = c_mem[out_idx];
        if (give && out_idx == LAST) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_col[l] = IW'(int'(grp) * LANES + l);

    mac_lane #(.WIDTH(WIDTH), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state == COMPUTE),
      .first    (rk == '0),
      .acc_flag (acc_flag),
      .a        (a_mem[ri][rk*WIDTH +: WIDTH]),
      .b        (b_mem[rk][lane_col[l]*WIDTH +: WIDTH]),
      .c_in     (c_mem[ri][lane_col[l]*ACC_W +: ACC_W]),
      .sum      (lane_sum[l])
`ifdef MATRIX_MULT_SEQ_SAT_EN
      , .sat    (lane_sat[l])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat     <= '0;
      ri       <= '0;
      grp      <= '0;
      rk       <= '0;
      acc_flag <= 1'b0;
      out_idx  <= '0;
      done     <= 1'b0;
      for (int r = 0; r < N; r++) begin
        a_mem[r] <= '0;
        b_mem[r] <= '0;
        c_mem[r] <= '0;
      end
`ifdef MATRIX_MULT_SEQ_SAT_EN
      ovf      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: if (take) begin
          if (beat < NB) a_mem[ld_row] <= in_row;
          else           b_mem[ld_row] <= in_row;
          if (beat == '0) begin
            acc_flag <= acc_en;
`ifdef MATRIX_MULT_SEQ_SAT_EN
            ovf      <= 1'b0;
`endif
          end
          beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        end
        COMPUTE: begin
          // Lane accumulators hold the running dot product; C is written once per k sweep.
          if (rk == LAST) begin
            for (int l = 0; l < LANES; l++)
              c_mem[ri][lane_col[l]*ACC_W +: ACC_W] <= lane_sum[l];
            rk <= '0;
            if (grp == JG_LAST) begin
              grp <= '0;
              ri  <= (ri == LAST) ? '0 : ri + 1'b1;
            end else begin
              grp <= grp + 1'b1;
            end
          end else begin
            rk <= rk + 1'b1;
          end
`ifdef MATRIX_MULT_SEQ_SAT_EN
          if (|lane_sat) ovf <= 1'b1;
`endif
        end
        DRAIN: if (give) begin
          if (out_idx == LAST) begin
            out_idx <= '0;
            done    <= 1'b1;
          end else begin
            out_idx <= out_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench: three matrix_mult_seq builds (unsigned x1 lane,
// unsigned x4 lanes, signed x2 lanes) driven by a job table plus a scoreboard.
module tb_matrix_mult_seq;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 35;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           acc_en;
  logic [N*W-1:0] in_row;
  logic           in_valid_v  [ND];
  logic           out_ready_v [ND];
  logic           in_ready_v  [ND];
  logic           out_valid_v [ND];
  logic           busy_v      [ND];
  logic           done_v      [ND];
  logic [N*AW-1:0] out_row_v  [ND];
  logic [1:0]     out_idx_v   [ND];
`ifdef MATRIX_MULT_SEQ_SAT_EN
  logic           ovf_v       [ND];
`endif

  matrix_mult_seq #(.N(N), .WIDTH(W), .LANES(1), .SIGNED(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_row(in_row), .acc_en(acc_en), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_row(out_row_v[0]), .out_idx(out_idx_v[0]), .busy(busy_v[0]), .done(done_v[0])
`ifdef MATRIX_MULT_SEQ_SAT_EN
    , .ovf(ovf_v[0])
`endif
  );

  matrix_mult_seq #(.N(N), .WIDTH(W), .LANES(4), .SIGNED(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_row(in_row), .acc_en(acc_en), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_row(out_row_v[1]), .out_idx(out_idx_v[1]), .busy(busy_v[1]), .done(done_v[1])
`ifdef MATRIX_MULT_SEQ_SAT_EN
    , .ovf(ovf_v[1])
`endif
  );

  matrix_mult_seq #(.N(N), .WIDTH(W), .LANES(2), .SIGNED(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_row(in_row), .acc_en(acc_en), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_row(out_row_v[2]), .out_idx(out_idx_v[2]), .busy(busy_v[2]), .done(done_v[2])
`ifdef MATRIX_MULT_SEQ_SAT_EN
    , .ovf(ovf_v[2])
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int              idx;
    logic [N*AW-1:0] row;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int            d;
    bit            acc;
    int            ak;
    int            bk;
    bit            gaps;
    int            stall;
    int            lat;
    logic [AW-1:0] c33;
  } job_t;

  logic [AW-1:0] mc [ND][N][N];
  int            done_cnt [ND];

  task automatic chk(input string nm, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (done_v[d] === 1'b1) done_cnt[d]++;
      if (rst_n === 1'b1 && in_ready_v[d] === 1'b1 && out_valid_v[d] === 1'b1) begin
        bad++;
        $display("FAIL handshake_excl dut%0d: in_ready and out_valid both 1", d);
      end
    end
  end

  function automatic logic [W-1:0] elem(input int kind, input int i, input int j);
    case (kind)
      0:       return W'(i + j);
      1:       return (i == j) ? 16'd1 : 16'd0;
      2:       return 16'hFFFF;
      default: return 16'd2;
    endcase
  endfunction

  function automatic logic [AW-1:0] mac_model(input logic [AW-1:0] base, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input bit sgn);
    longint bv, p, s;
    bv = longint'({29'd0, base});
    if (sgn) begin
      if (base[AW-1]) bv = bv - (longint'(1) <<< AW);
      p = longint'($signed(a)) * longint'($signed(b));
    end else begin
      p = longint'({48'd0, a}) * longint'({48'd0, b});
    end
    s = bv + p;
`ifdef MATRIX_MULT_SEQ_SAT_EN
    if (sgn) begin
      if (s > (longint'(1) <<< (AW - 1)) - 1) s = (longint'(1) <<< (AW - 1)) - 1;
      else if (s < -(longint'(1) <<< (AW - 1))) s = -(longint'(1) <<< (AW - 1));
    end else if (s > (longint'(1) <<< AW) - 1) begin
      s = (longint'(1) <<< AW) - 1;
    end
`endif
    return s[AW-1:0];
  endfunction

  task automatic load_beats(input int d, input bit acc, input int ak, input int bk,
                            input bit gaps, output bit ok);
    int guard;
    ok = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 2 * N; b++) begin
      if (gaps) begin
        in_valid_v[d] = 1'b0;
        in_row = {$urandom, $urandom};
        acc_en = $urandom_range(0, 1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int j = 0; j < N; j++)
        in_row[j*W +: W] = (b < N) ? elem(ak, b, j) : elem(bk, b - N, j);
      acc_en = (b == 0) ? acc : ~acc;
      in_valid_v[d] = 1'b1;
      guard = 0;
      while (in_ready_v[d] !== 1'b1) begin
        @(posedge clk); #1;
        guard++;
        if (guard > 100) begin
          chk("load_timeout", 0, 1);
          in_valid_v[d] = 1'b0;
          ok = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    in_valid_v[d] = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    bit ok;
    int cnt, dc0;
    logic [AW-1:0] v;
    logic [N*AW-1:0] row, snap_row;
    logic [1:0] snap_idx;
    logic [AW-1:0] c33;
    exp_t e;

    dc0 = done_cnt[j.d];
    load_beats(j.d, j.acc, j.ak, j.bk, j.gaps, ok);
    if (!ok) return;

    for (int i = 0; i < N; i++) begin
      row = '0;
      for (int c = 0; c < N; c++) begin
        v = j.acc ? mc[j.d][i][c] : '0;
        for (int k = 0; k < N; k++)
          v = mac_model(v, elem(j.ak, i, k), elem(j.bk, k, c), j.d == 2);
        mc[j.d][i][c] = v;
        row[c*AW +: AW] = v;
      end
      e.idx = i;
      e.row = row;
      sbq.push_back(e);
    end

    chk("busy_in_compute", busy_v[j.d], 1);
    chk("in_ready_in_compute", in_ready_v[j.d], 0);
    cnt = 0;
    while (out_valid_v[j.d] !== 1'b1 && cnt <= 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, j.lat);
    if (out_valid_v[j.d] !== 1'b1) return;

    c33 = '0;
    for (int r = 0; r < N; r++) begin
      if (r == j.stall) begin
        out_ready_v[j.d] = 1'b0;
        snap_row = out_row_v[j.d];
        snap_idx = out_idx_v[j.d];
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall_row_hold", out_row_v[j.d], snap_row);
          chk("stall_idx_hold", out_idx_v[j.d], snap_idx);
        end
      end
      out_ready_v[j.d] = 1'b1;
      chk("drain_valid", out_valid_v[j.d], 1);
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("out_idx", out_idx_v[j.d], e.idx);
        chk("out_row", out_row_v[j.d], e.row);
      end
      if (r == N - 1) c33 = out_row_v[j.d][3*AW +: AW];
      @(posedge clk); #1;
    end
    out_ready_v[j.d] = 1'b0;
    chk("c33_value", c33, j.c33);
    chk("done_pulse", done_v[j.d], 1);
    chk("valid_low_after_drain", out_valid_v[j.d], 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done_v[j.d], 0);
    chk("done_count", done_cnt[j.d], dc0 + 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < N; i++)
        for (int c = 0; c < N; c++)
          mc[d][i][c] = '0;
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_in_ready", in_ready_v[d], 0);
    chk("rst_out_valid", out_valid_v[d], 0);
    chk("rst_out_row", out_row_v[d], 0);
    chk("rst_out_idx", out_idx_v[d], 0);
    chk("rst_busy", busy_v[d], 0);
    chk("rst_done", done_v[d], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t jobs[5];
    job_t hj;
    bit   ok;

    jobs[0] = '{d: 0, acc: 1'b0, ak: 0, bk: 1, gaps: 1'b0, stall: 1,  lat: 64, c33: 35'd6};
    jobs[1] = '{d: 1, acc: 1'b0, ak: 0, bk: 1, gaps: 1'b1, stall: -1, lat: 16, c33: 35'd6};
    jobs[2] = '{d: 0, acc: 1'b1, ak: 0, bk: 1, gaps: 1'b0, stall: -1, lat: 64, c33: 35'd12};
    jobs[3] = '{d: 2, acc: 1'b0, ak: 2, bk: 3, gaps: 1'b0, stall: 2,  lat: 32, c33: 35'h7_FFFF_FFF8};
    jobs[4] = '{d: 0, acc: 1'b0, ak: 2, bk: 3, gaps: 1'b0, stall: -1, lat: 64, c33: 35'd524280};

    rst_n  = 1'b0;
    acc_en = 1'b0;
    in_row = '0;
    for (int d = 0; d < ND; d++) begin
      in_valid_v[d]  = 1'b0;
      out_ready_v[d] = 1'b0;
      done_cnt[d]    = 0;
      for (int i = 0; i < N; i++)
        for (int c = 0; c < N; c++)
          mc[d][i][c] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_reset_outputs(d);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) run_job(jobs[t]);

    // Abandon a job mid-compute; the next accumulate job must start from a cleared C.
    load_beats(0, 1'b0, 0, 1, 1'b0, ok);
    repeat (10) @(posedge clk);
    #1 chk("busy_before_reset", busy_v[0], 1);
    pulse_reset();
    check_reset_outputs(0);
    rst_n = 1'b1;
    hj = '{d: 0, acc: 1'b1, ak: 0, bk: 1, gaps: 1'b0, stall: -1, lat: 64, c33: 35'd6};
    run_job(hj);

`ifdef MATRIX_MULT_SEQ_SAT_EN
    pulse_reset();
    rst_n = 1'b1;
    hj = '{d: 0, acc: 1'b0, ak: 2, bk: 2, gaps: 1'b0, stall: -1, lat: 64, c33: 35'd17179344900};
    run_job(hj);
    chk("ovf_clear_after_job1", ovf_v[0], 0);
    hj = '{d: 0, acc: 1'b1, ak: 2, bk: 2, gaps: 1'b0, stall: -1, lat: 64, c33: 35'd34358689800};
    run_job(hj);
    chk("ovf_clear_after_job2", ovf_v[0], 0);
    hj = '{d: 0, acc: 1'b1, ak: 2, bk: 2, gaps: 1'b0, stall: -1, lat: 64, c33: 35'h7_FFFF_FFFF};
    run_job(hj);
    chk("ovf_set_on_clamp", ovf_v[0], 1);
    hj = '{d: 0, acc: 1'b0, ak: 0, bk: 1, gaps: 1'b0, stall: -1, lat: 64, c33: 35'd6};
    run_job(hj);
    chk("ovf_cleared_by_beat0", ovf_v[0], 0);
`endif

    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
